// File: rtl/stack.sv
// ---------------------------------------------------------------------------
// Stack
//
// Purpose:
//   Single-cycle LIFO of STACK_SIZE words of N bits each. One push, one pop,
//   or a combined push+pop (replace top, return old top) completes per clock.
//   Requests that cannot be honoured (push when full, pop when empty) are
//   silently dropped; full/empty are the only flow-control signals.
//
// Parameters:
//   N           data word width in bits
//   STACK_SIZE  maximum number of stored entries (>= 2)
//
// Ports:
//   clk        in   rising-edge clock for all state
//   reset      in   asynchronous active-high reset (clears everything)
//   push       in   push request, sampled on rising clk
//   pop        in   pop request, sampled on rising clk
//   push_data  in   word written on an accepted push
//   pop_data   out  registered word removed by the last accepted pop
//   top        out  combinational view of the current top entry (0 if empty)
//   empty      out  stack holds 0 entries
//   full       out  stack holds STACK_SIZE entries
// ---------------------------------------------------------------------------
module stack #(
    parameter int N          = 16,
    parameter int STACK_SIZE = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] push_data,
    output logic [N-1:0] pop_data,
    output logic [N-1:0] top,
    output logic         empty,
    output logic         full
);

    // sp needs to represent 0..STACK_SIZE inclusive; memory indices only
    // need 0..STACK_SIZE-1.
    localparam int SPW = $clog2(STACK_SIZE + 1);
    localparam int AW  = (STACK_SIZE > 1) ? $clog2(STACK_SIZE) : 1;

    logic [N-1:0]   mem_q [STACK_SIZE];
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_d;
    logic [N-1:0]   popData_q;
    logic [N-1:0]   popData_d;

    logic [SPW-1:0] spMinus1;
    logic [AW-1:0]  topIdx;
    logic [AW-1:0]  wrIdx;
    logic           wrEn;
    logic [N-1:0]   wrData;
    logic           unusedSpBits;

    assign empty    = (sp_q == '0);
    assign full     = (sp_q == SPW'(STACK_SIZE));
    assign spMinus1 = sp_q - SPW'(1);
    assign topIdx   = spMinus1[AW-1:0];

    // The high bits of sp never reach a memory index; they are consumed here
    // only so the truncation above is visibly intentional.
    assign unusedSpBits = ^{sp_q, spMinus1};

    assign top      = empty ? '0 : mem_q[topIdx];
    assign pop_data = popData_q;

    // Next-state decode. A combined push+pop on a non-empty stack replaces
    // the top entry in place (sp unchanged, full does not matter). On an
    // empty stack the pop half has nothing to return, so the pair degrades
    // to a plain push into mem[0].
    always_comb begin
        sp_d      = sp_q;
        popData_d = popData_q;
        wrEn      = 1'b0;
        wrIdx     = sp_q[AW-1:0];
        wrData    = push_data;

        if (push && pop) begin
            if (empty) begin
                wrEn  = 1'b1;
                wrIdx = '0;
                sp_d  = sp_q + SPW'(1);
            end else begin
                wrEn      = 1'b1;
                wrIdx     = topIdx;
                popData_d = mem_q[topIdx];
            end
        end else if (push) begin
            if (!full) begin
                wrEn  = 1'b1;
                wrIdx = sp_q[AW-1:0];
                sp_d  = sp_q + SPW'(1);
            end
        end else if (pop) begin
            if (!empty) begin
                popData_d = mem_q[topIdx];
                sp_d      = spMinus1;
            end
        end
    end

    // State registers. Reset wipes the whole array as well as sp and
    // pop_data so that no stale word can ever appear on top after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q      <= '0;
            popData_q <= '0;
            for (int i = 0; i < STACK_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q      <= sp_d;
            popData_q <= popData_d;
            if (wrEn) begin
                mem_q[wrIdx] <= wrData;
            end
        end
    end

`ifndef SYNTHESIS
    // Debug helper, called hierarchically from a bench: dumps the live
    // entries from bottom (mem[0]) to top (mem[sp-1]).
    task automatic print_stack();
        $display("stack: sp=%0d", sp_q);
        if (sp_q == '0) begin
            $display("stack: empty");
        end else begin
            for (int i = 0; i < int'(sp_q); i++) begin
                $display("stack:   mem[%0d] = %0d", i, mem_q[i]);
            end
        end
    endtask
`endif

endmodule

// File: tb/tb_stack.sv
// ---------------------------------------------------------------------------
// tb_stack
//
// Directed bench for the stack: reset state, push/pop ordering, fill to full
// and drain to empty, ignored overflow/underflow, combined push+pop on empty
// and non-empty stacks, and asynchronous reset mid-cycle.
// ---------------------------------------------------------------------------
module tb_stack;

    localparam int N          = 16;
    localparam int STACK_SIZE = 16;

    logic         clk;
    logic         reset;
    logic         push;
    logic         pop;
    logic [N-1:0] push_data;
    logic [N-1:0] pop_data;
    logic [N-1:0] top;
    logic         empty;
    logic         full;

    int checkCount;
    int failCount;

    stack #(
        .N         (N),
        .STACK_SIZE(STACK_SIZE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_data(push_data),
        .pop_data (pop_data),
        .top      (top),
        .empty    (empty),
        .full     (full)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                               input logic [N-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present one request for exactly one rising edge, then leave the bench
    // 1 ns past that edge with the request lines idle, ready for sampling.
    task automatic applyStimulus(input logic doPush, input logic doPop,
                                 input logic [N-1:0] data);
        push      = doPush;
        pop       = doPop;
        push_data = data;
        @(posedge clk);
        #1;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        push       = 1'b0;
        pop        = 1'b0;
        push_data  = '0;
        reset      = 1'b1;

        // Reset for a cycle, then release between edges.
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_empty",    N'(empty), 16'd1);
        checkOutput("reset_full",     N'(full),  16'd0);
        checkOutput("reset_top",      top,       16'd0);
        checkOutput("reset_pop_data", pop_data,  16'd0);

        // Basic pushes.
        applyStimulus(1'b1, 1'b0, 16'd10);
        checkOutput("push10_top",   top,       16'd10);
        checkOutput("push10_empty", N'(empty), 16'd0);
        applyStimulus(1'b1, 1'b0, 16'd20);
        checkOutput("push20_top",   top,       16'd20);
        checkOutput("push20_empty", N'(empty), 16'd0);
        dut.print_stack();

        // Pop / push / pop ordering.
        applyStimulus(1'b0, 1'b1, 16'd0);
        checkOutput("pop20_data", pop_data, 16'd20);
        checkOutput("pop20_top",  top,      16'd10);
        applyStimulus(1'b1, 1'b0, 16'd30);
        checkOutput("push30_top", top,      16'd30);
        checkOutput("push30_pop_data_hold", pop_data, 16'd20);
        applyStimulus(1'b0, 1'b1, 16'd0);
        checkOutput("pop30_data",  pop_data,  16'd30);
        checkOutput("pop30_top",   top,       16'd10);
        checkOutput("pop30_empty", N'(empty), 16'd0);
        applyStimulus(1'b0, 1'b1, 16'd0);
        checkOutput("pop10_data",  pop_data,  16'd10);
        checkOutput("pop10_empty", N'(empty), 16'd1);
        checkOutput("pop10_top",   top,       16'd0);

        // Fill with 100, 103, ..., 145.
        for (int i = 0; i < STACK_SIZE; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(100 + 3 * i));
            checkOutput("fill_top", top, 16'(100 + 3 * i));
            if (i == STACK_SIZE - 2) checkOutput("fill_not_full", N'(full), 16'd0);
        end
        checkOutput("fill_full",  N'(full),  16'd1);
        checkOutput("fill_empty", N'(empty), 16'd0);

        // Overflow push is dropped.
        applyStimulus(1'b1, 1'b0, 16'd999);
        checkOutput("overflow_top",      top,      16'd145);
        checkOutput("overflow_full",     N'(full), 16'd1);
        checkOutput("overflow_pop_data", pop_data, 16'd10);

        // Drain in reverse order.
        for (int i = STACK_SIZE - 1; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, 16'd0);
            checkOutput("drain_pop_data", pop_data, 16'(100 + 3 * i));
            if (i == STACK_SIZE - 1) checkOutput("drain_not_full", N'(full), 16'd0);
        end
        checkOutput("drain_empty", N'(empty), 16'd1);

        // Underflow pop is dropped.
        applyStimulus(1'b0, 1'b1, 16'd0);
        checkOutput("underflow_pop_data", pop_data,  16'd100);
        checkOutput("underflow_empty",    N'(empty), 16'd1);

        // Combined push+pop on {5, 7}: replaces 7 with 9, depth stays 2.
        applyStimulus(1'b1, 1'b0, 16'd5);
        applyStimulus(1'b1, 1'b0, 16'd7);
        checkOutput("pre_swap_top", top, 16'd7);
        applyStimulus(1'b1, 1'b1, 16'd9);
        checkOutput("swap_pop_data", pop_data, 16'd7);
        checkOutput("swap_top",      top,      16'd9);
        applyStimulus(1'b0, 1'b1, 16'd0);
        checkOutput("swap_pop9",     pop_data, 16'd9);
        checkOutput("swap_top5",     top,      16'd5);
        applyStimulus(1'b0, 1'b1, 16'd0);
        checkOutput("swap_pop5",     pop_data,  16'd5);
        checkOutput("swap_empty",    N'(empty), 16'd1);

        // Combined push+pop on empty behaves as a plain push.
        applyStimulus(1'b1, 1'b1, 16'd9);
        checkOutput("swap_empty_top",      top,       16'd9);
        checkOutput("swap_empty_nonempty", N'(empty), 16'd0);
        checkOutput("swap_empty_pop_data", pop_data,  16'd5);
        applyStimulus(1'b0, 1'b1, 16'd0);
        checkOutput("swap_empty_pop9",     pop_data,  16'd9);
        checkOutput("swap_empty_depth1",   N'(empty), 16'd1);

        // Asynchronous reset mid-cycle with three entries stored.
        applyStimulus(1'b1, 1'b0, 16'd1);
        applyStimulus(1'b1, 1'b0, 16'd2);
        applyStimulus(1'b1, 1'b0, 16'd3);
        checkOutput("pre_areset_top", top, 16'd3);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("areset_empty",    N'(empty), 16'd1);
        checkOutput("areset_top",      top,       16'd0);
        checkOutput("areset_pop_data", pop_data,  16'd0);
        checkOutput("areset_full",     N'(full),  16'd0);

        // Requests while reset is held are discarded.
        push      = 1'b1;
        push_data = 16'd77;
        @(posedge clk);
        #1;
        push = 1'b0;
        checkOutput("in_reset_push_empty", N'(empty), 16'd1);
        reset = 1'b0;

        // Normal operation resumes after release.
        applyStimulus(1'b1, 1'b0, 16'd4);
        checkOutput("post_reset_top", top, 16'd4);
        applyStimulus(1'b0, 1'b1, 16'd0);
        checkOutput("post_reset_pop", pop_data,  16'd4);
        checkOutput("post_reset_empty", N'(empty), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/stack.md
STACK -- requirements
Module: stack

Interface
REQ-001 Parameter N, default 16, data word width in bits.
REQ-002 Parameter STACK_SIZE, default 16, maximum number of stored entries (>= 2).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 push  input  1  push request, sampled on rising clk.
REQ-006 pop  input  1  pop request, sampled on rising clk.
REQ-007 push_data  input  N  word written on an accepted push.
REQ-008 pop_data  output  N  registered word removed by the last accepted pop.
REQ-009 top  output  N  combinational view of the current top-of-stack entry.
REQ-010 empty  output  1  high when the stack holds 0 entries.
REQ-011 full  output  1  high when the stack holds STACK_SIZE entries.

Function
REQ-012 The block SHALL be a LIFO with STACK_SIZE x N storage and an occupancy counter sp in the range 0..STACK_SIZE.
REQ-013 empty SHALL be (sp == 0) and full SHALL be (sp == STACK_SIZE), both decoded combinationally from sp.
REQ-014 top SHALL equal mem[sp-1] when sp > 0, and SHALL be 0 when empty.
REQ-015 Push-only (push=1, pop=0, not full) SHALL write push_data to mem[sp] and increment sp on the same rising edge; top shows the new word in the following cycle.
REQ-016 Push-only while full SHALL be ignored: storage, sp and pop_data unchanged.
REQ-017 Pop-only (pop=1, push=0, not empty) SHALL load pop_data with mem[sp-1] and decrement sp on the same rising edge.
REQ-018 Pop-only while empty SHALL be ignored: sp unchanged, pop_data holds its previous value.
REQ-019 pop_data SHALL hold its value in every cycle without an accepted pop.
REQ-020 Simultaneous push and pop when not empty SHALL load pop_data with mem[sp-1], overwrite mem[sp-1] with push_data, and leave sp unchanged (full is irrelevant to this case).
REQ-021 Simultaneous push and pop when empty SHALL act as push-only: write mem[0], sp becomes 1, pop_data unchanged.
REQ-022 Each accepted operation SHALL complete in one clock cycle; there is no handshake or back-pressure beyond the full/empty flags.
REQ-023 sp SHALL never wrap: it never exceeds STACK_SIZE and never goes below 0.
REQ-024 The module SHALL provide a simulation-only task print_stack, callable hierarchically, that displays sp and entries mem[0]..mem[sp-1] bottom to top, and prints an "empty" notice when sp == 0; the task has no effect on synthesized logic.

Reset
REQ-025 Asserting reset SHALL immediately, independent of clk, set sp=0, pop_data=0 and clear all storage entries to 0; consequently empty=1, full=0 and top=0.
REQ-026 Reset SHALL take priority over push and pop; requests presented while reset is high are discarded, including any operation in flight at reset assertion.
REQ-027 Normal operation SHALL resume on the first rising clk edge after reset deasserts.

Verification
REQ-028 Assert reset for one cycle, then release -> empty=1, full=0, top=0, pop_data=0.
REQ-029 Push 10, then push 20, one cycle each -> top=10 after the first push, top=20 and empty=0 after the second; print_stack lists 10, 20.
REQ-030 Pop one cycle -> pop_data=20, top=10; push 30 -> top=30; pop -> pop_data=30, top=10, with sp=1 throughout the final state.
REQ-031 Push 16 distinct words from empty -> full=1 after the 16th; a 17th push is ignored (top unchanged). Then 16 pops return the words in reverse order, after which empty=1. A further pop leaves pop_data unchanged.
REQ-032 Starting with stack holding 5 and 7 (top=7), assert push=1 (data 9) and pop=1 together for one cycle -> pop_data=7, top=9, sp stays 2. The same stimulus while empty -> top=9, sp=1, pop_data unchanged.
REQ-033 Assert reset asynchronously mid-cycle with 3 entries stored -> empty=1, top=0 and pop_data=0 before the next clk edge.
